dm_abstract_ctl: RTL and testbench

- Debug-module-side sequencer that sits directly upstream of the core's hart debug controller.
- Turns dmcontrol halt/resume requests and abstract command writes from the DM register file into the hart-facing debug handshake: halt_req, resume_req, command, exec.
- Collects done, error and exception from the hart and reports abstractcs busy/cmderr plus resumeack.
- Single hart, one command in flight at a time.

---
 rtl/dm_abstract_ctl.sv | 193 +++++++++++++++++++
 tb/tb_dm_abstract_ctl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_abstract_ctl.sv
// dm_abstract_ctl: debug-module sequencer between the DM register file and the
// hart debug controller. Turns haltreq/resumereq and abstract command writes
// into the hart handshake, and reports abstractcs busy/cmderr and resumeack.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   haltreq, resumereq  dmcontrol halt level / resume write pulse
//   cmd_wr, cmd_wdata   command register write pulse and value
//   autoexec_trig       data0 access with abstractauto set (see macro below)
//   cmderr_w1c          abstractcs.cmderr write-1-to-clear bits
//   hart_*              hart status: halted, done, write, error, exception
//   halt_req, resume_req, command, exec   hart-facing handshake
//   data0_we            data0 capture enable (hart_write qualified by exec)
//   busy, cmderr, resumeack               status back to the register file
//
// Build option: define DEBUG_AUTOEXEC_EN to let autoexec_trig start commands;
// without it the port is present but ignored.

module dm_abstract_ctl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_W      = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        haltreq,
    input  logic        resumereq,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_wdata,
    input  logic        autoexec_trig,
    input  logic [2:0]  cmderr_w1c,
    input  logic        hart_halted,
    input  logic        hart_done,
    input  logic        hart_write,
    input  logic        hart_error,
    input  logic        hart_exception,
    output logic        halt_req,
    output logic        resume_req,
    output logic [31:0] command,
    output logic        exec,
    output logic        data0_we,
    output logic        busy,
    output logic [2:0]  cmderr,
    output logic        resumeack
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] CMDTYPE_REG = 8'd0;
    localparam logic [7:0] CMDTYPE_MEM = 8'd2;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_NOTSUP  = 3'd2;
    localparam logic [2:0] ERR_EXC     = 3'd3;
    localparam logic [2:0] ERR_HALT    = 3'd4;
    localparam logic [2:0] ERR_BUS     = 3'd5;
    localparam logic [2:0] ERR_TIMEOUT = 3'd7;

    localparam int unsigned POSTEXEC_BIT = 18;
    localparam int unsigned TRANSFER_BIT = 17;

    logic [1:0]           state, state_nxt;
    logic [TIMEOUT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [31:0]          command_nxt;
    logic [2:0]           err_set, cmderr_nxt;
    logic                 resume_req_nxt, resumeack_nxt;
    logic                 trig;
    logic [7:0]           cmdtype;

    // Command start sources.
`ifdef DEBUG_AUTOEXEC_EN
    assign trig = cmd_wr | autoexec_trig;
`else
    logic unused_autoexec;
    assign unused_autoexec = autoexec_trig;
    assign trig            = cmd_wr;
`endif

    assign cmdtype  = command[31:24];
    assign cnt_inc  = cnt + TIMEOUT_W'(1);
    // exec is a registered decode of EXEC, so this follows hart_write in-cycle.
    assign data0_we = exec & hart_write;

    // Next-state, error and resume handshake logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        command_nxt    = command;
        err_set        = ERR_NONE;
        resume_req_nxt = resume_req;
        resumeack_nxt  = resumeack;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (trig && (cmderr == ERR_NONE)) begin
                    if (cmd_wr) begin
                        command_nxt = cmd_wdata;
                    end
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (((cmdtype != CMDTYPE_REG) && (cmdtype != CMDTYPE_MEM)) ||
                    ((cmdtype == CMDTYPE_REG) && command[POSTEXEC_BIT])) begin
                    err_set   = ERR_NOTSUP;
                    state_nxt = ST_DONE;
                end else if (!hart_halted) begin
                    err_set   = ERR_HALT;
                    state_nxt = ST_DONE;
                end else if ((cmdtype == CMDTYPE_REG) && !command[TRANSFER_BIT]) begin
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (hart_done) begin
                    if (hart_exception) begin
                        err_set = ERR_EXC;
                    end else if (hart_error) begin
                        err_set = (cmdtype == CMDTYPE_MEM) ? ERR_BUS : ERR_EXC;
                    end
                    state_nxt = ST_DONE;
                end else if (cnt_inc == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                    err_set   = ERR_TIMEOUT;
                    state_nxt = ST_DONE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // A new start while a command is running is reported as busy.
        if (busy && trig && (err_set == ERR_NONE)) begin
            err_set = ERR_BUSY;
        end

        // Sticky error: only the first error lands; a landing error beats w1c.
        if ((cmderr == ERR_NONE) && (err_set != ERR_NONE)) begin
            cmderr_nxt = err_set;
        end else begin
            cmderr_nxt = cmderr & ~cmderr_w1c;
        end

        // Resume: hold the request until the hart leaves halt; halt wins.
        if (resume_req) begin
            if (!hart_halted) begin
                resume_req_nxt = 1'b0;
                resumeack_nxt  = 1'b1;
            end
        end else if (resumereq && hart_halted && !haltreq) begin
            resume_req_nxt = 1'b1;
            resumeack_nxt  = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            command    <= '0;
            cmderr     <= ERR_NONE;
            halt_req   <= 1'b0;
            resume_req <= 1'b0;
            resumeack  <= 1'b0;
            exec       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            command    <= command_nxt;
            cmderr     <= cmderr_nxt;
            halt_req   <= haltreq;
            resume_req <= resume_req_nxt;
            resumeack  <= resumeack_nxt;
            exec       <= (state_nxt == ST_EXEC);
            busy       <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dm_abstract_ctl.sv
// tb_dm_abstract_ctl: self-checking bench for dm_abstract_ctl. Each started
// command pushes its expected completion (cmderr, command, exec and busy
// cycle counts) to a queue; a monitor pops and compares when busy falls.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_dm_abstract_ctl;

    localparam int unsigned TO_CYCLES = 8;
    localparam int unsigned TO_W      = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        haltreq, resumereq, cmd_wr, autoexec_trig;
    logic [31:0] cmd_wdata;
    logic [2:0]  cmderr_w1c;
    logic        hart_halted, hart_done, hart_write, hart_error, hart_exception;
    logic        halt_req, resume_req, exec, data0_we, busy, resumeack;
    logic [31:0] command;
    logic [2:0]  cmderr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  err;
        logic [31:0] cmd;
        int          exec_cyc;
        int          busy_cyc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dm_abstract_ctl #(
        .TIMEOUT_CYCLES(TO_CYCLES),
        .TIMEOUT_W     (TO_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .haltreq       (haltreq),
        .resumereq     (resumereq),
        .cmd_wr        (cmd_wr),
        .cmd_wdata     (cmd_wdata),
        .autoexec_trig (autoexec_trig),
        .cmderr_w1c    (cmderr_w1c),
        .hart_halted   (hart_halted),
        .hart_done     (hart_done),
        .hart_write    (hart_write),
        .hart_error    (hart_error),
        .hart_exception(hart_exception),
        .halt_req      (halt_req),
        .resume_req    (resume_req),
        .command       (command),
        .exec          (exec),
        .data0_we      (data0_we),
        .busy          (busy),
        .cmderr        (cmderr),
        .resumeack     (resumeack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] err, input logic [31:0] cmd,
                            input int ex, input int bz);
        exp_t e;
        e.err      = err;
        e.cmd      = cmd;
        e.exec_cyc = ex;
        e.busy_cyc = bz;
        exp_q.push_back(e);
    endtask

    task automatic issue_cmd(input logic [31:0] c);
        cmd_wdata = c;
        cmd_wr    = 1'b1;
        @(negedge clk);
        cmd_wr    = 1'b0;
    endtask

    task automatic wait_exec();
        for (int i = 0; i < 20 && !exec; i++) @(negedge clk);
        check("exec_rise", 32'(exec), 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) @(negedge clk);
        check("busy_fall", 32'(busy), 32'd0);
    endtask

    task automatic clear_err();
        cmderr_w1c = 3'b111;
        @(negedge clk);
        cmderr_w1c = 3'b000;
        check("cmderr_clr", 32'(cmderr), 32'd0);
    endtask

    // Completion monitor: counts exec/busy cycles and scores each command.
    initial begin
        exp_t e;
        logic busy_d   = 1'b0;
        int   mon_exec = 0;
        int   mon_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_d   = 1'b0;
                mon_exec = 0;
                mon_busy = 0;
            end else begin
                if (busy) mon_busy++;
                if (exec) mon_exec++;
                if (busy_d && !busy) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_cmderr", 32'(cmderr), 32'(e.err));
                        check("sb_command", command, e.cmd);
                        check("sb_exec_cycles", 32'(mon_exec), 32'(e.exec_cyc));
                        check("sb_busy_cycles", 32'(mon_busy), 32'(e.busy_cyc));
                    end
                    mon_exec = 0;
                    mon_busy = 0;
                end
                busy_d = busy;
            end
        end
    end

    initial begin
        rst_n = 1'b0; haltreq = 1'b0; resumereq = 1'b0; cmd_wr = 1'b0;
        cmd_wdata = '0; autoexec_trig = 1'b0; cmderr_w1c = '0;
        hart_halted = 1'b0; hart_done = 1'b0; hart_write = 1'b0;
        hart_error = 1'b0; hart_exception = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_halt_req", 32'(halt_req), 32'd0);
        check("rst_resume_req", 32'(resume_req), 32'd0);
        check("rst_command", command, 32'd0);
        check("rst_exec", 32'(exec), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmderr", 32'(cmderr), 32'd0);
        check("rst_resumeack", 32'(resumeack), 32'd0);
        check("rst_data0_we", 32'(data0_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // halt_req is one cycle behind haltreq
        haltreq = 1'b1;
        check("halt_lat0", 32'(halt_req), 32'd0);
        @(negedge clk);
        check("halt_set", 32'(halt_req), 32'd1);
        haltreq = 1'b0;
        @(negedge clk);
        check("halt_clr", 32'(halt_req), 32'd0);

        // data0_we stays low outside EXEC
        hart_write = 1'b1;
        #1 check("we_idle", 32'(data0_we), 32'd0);
        hart_write = 1'b0;

        // Access register, done 3 cycles after exec
        hart_halted = 1'b1;
        push_exp(3'd0, 32'h0022_1000, 4, 6);
        issue_cmd(32'h0022_1000);
        check("busy_rise", 32'(busy), 32'd1);
        check("exec_check", 32'(exec), 32'd0);
        wait_exec();
        check("cmd_latch", command, 32'h0022_1000);
        hart_write = 1'b1;
        #1 check("we_exec", 32'(data0_we), 32'd1);
        @(negedge clk);
        hart_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        hart_done = 1'b1;
        @(negedge clk);
        hart_done = 1'b0;
        check("done_exec", 32'(exec), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        wait_idle(5);

        // Hart not halted -> cmderr 4, partial w1c keeps it
        hart_halted = 1'b0;
        push_exp(3'd4, 32'h0022_1000, 0, 2);
        issue_cmd(32'h0022_1000);
        @(negedge clk);
        check("nothalt_err", 32'(cmderr), 32'd4);
        wait_idle(5);
        cmderr_w1c = 3'b011;
        @(negedge clk);
        cmderr_w1c = 3'b000;
        check("w1c_partial", 32'(cmderr), 32'd4);
        clear_err();

        // Access memory with hart error -> cmderr 5
        hart_halted = 1'b1;
        push_exp(3'd5, 32'h0200_0000, 2, 4);
        issue_cmd(32'h0200_0000);
        wait_exec();
        @(negedge clk);
        hart_done = 1'b1; hart_error = 1'b1;
        @(negedge clk);
        hart_done = 1'b0; hart_error = 1'b0;
        check("memerr", 32'(cmderr), 32'd5);
        wait_idle(5);

        // Start while cmderr != 0 is ignored
        issue_cmd(32'h0022_1000);
        check("ign_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("ign_busy2", 32'(busy), 32'd0);
        check("ign_cmd", command, 32'h0200_0000);
        clear_err();

        // Exception has priority over error
        push_exp(3'd3, 32'h0200_0000, 1, 3);
        issue_cmd(32'h0200_0000);
        wait_exec();
        hart_done = 1'b1; hart_error = 1'b1; hart_exception = 1'b1;
        @(negedge clk);
        hart_done = 1'b0; hart_error = 1'b0; hart_exception = 1'b0;
        wait_idle(5);
        clear_err();

        // Unsupported type, postexec, and no-transfer commands
        push_exp(3'd2, 32'h0100_0000, 0, 2);
        issue_cmd(32'h0100_0000);
        wait_idle(5);
        clear_err();
        push_exp(3'd2, 32'h0026_1000, 0, 2);
        issue_cmd(32'h0026_1000);
        wait_idle(5);
        clear_err();
        push_exp(3'd0, 32'h0020_1000, 0, 2);
        issue_cmd(32'h0020_1000);
        wait_idle(5);

        // cmd_wr during EXEC -> cmderr 1, command kept
        push_exp(3'd1, 32'h0022_1000, 3, 5);
        issue_cmd(32'h0022_1000);
        wait_exec();
        cmd_wdata = 32'hdead_beef;
        cmd_wr    = 1'b1;
        @(negedge clk);
        cmd_wr    = 1'b0;
        check("busy_err", 32'(cmderr), 32'd1);
        check("busy_cmd", command, 32'h0022_1000);
        @(negedge clk);
        hart_done = 1'b1;
        @(negedge clk);
        hart_done = 1'b0;
        wait_idle(5);
        clear_err();

        // Resume handshake
        resumereq = 1'b1;
        @(negedge clk);
        resumereq = 1'b0;
        check("res_req", 32'(resume_req), 32'd1);
        check("res_ack0", 32'(resumeack), 32'd0);
        @(negedge clk);
        check("res_hold", 32'(resume_req), 32'd1);
        hart_halted = 1'b0;
        @(negedge clk);
        check("res_drop", 32'(resume_req), 32'd0);
        check("res_ack", 32'(resumeack), 32'd1);
        resumereq = 1'b1;
        @(negedge clk);
        resumereq = 1'b0;
        check("res_nothalt", 32'(resume_req), 32'd0);
        check("res_ack_keep", 32'(resumeack), 32'd1);
        hart_halted = 1'b1; haltreq = 1'b1; resumereq = 1'b1;
        @(negedge clk);
        resumereq = 1'b0; haltreq = 1'b0;
        check("res_halt_wins", 32'(resume_req), 32'd0);

        // Timeout
        push_exp(3'd7, 32'h0022_1000, TO_CYCLES, TO_CYCLES + 2);
        issue_cmd(32'h0022_1000);
        wait_idle(40);
        clear_err();

        // hart_done outside EXEC is ignored
        hart_done = 1'b1; hart_error = 1'b1;
        @(negedge clk);
        hart_done = 1'b0; hart_error = 1'b0;
        check("stray_done_err", 32'(cmderr), 32'd0);
        check("stray_done_busy", 32'(busy), 32'd0);

        // autoexec reuses the current command
`ifdef DEBUG_AUTOEXEC_EN
        push_exp(3'd0, 32'h0022_1000, 2, 4);
        autoexec_trig = 1'b1;
        @(negedge clk);
        autoexec_trig = 1'b0;
        check("auto_busy", 32'(busy), 32'd1);
        wait_exec();
        @(negedge clk);
        hart_done = 1'b1;
        @(negedge clk);
        hart_done = 1'b0;
        wait_idle(5);
`else
        autoexec_trig = 1'b1;
        @(negedge clk);
        autoexec_trig = 1'b0;
        check("auto_off_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("auto_off_busy2", 32'(busy), 32'd0);
        check("auto_off_err", 32'(cmderr), 32'd0);
`endif

        // Reset mid-command: no completion reported
        issue_cmd(32'h0022_1000);
        wait_exec();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_exec", 32'(exec), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd", command, 32'd0);
        check("midrst_err", 32'(cmderr), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
